fft_bfly_addr_gen: RTL and testbench

Read-side address sequencer for the in-place radix-2 DIT FFT memory. Once started, it walks every stage and butterfly and issues one (addr_a, addr_b, twiddle index) triple per butterfly over a valid/ready handshake. Between stages it waits a fixed number of cycles so the butterfly pipeline can finish writing back. Input data sits in memory in bit-reversed order before start.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_bfly_addr_gen_if.sv | 28 ++
 rtl/fft_bfly_addr_map.sv | 29 ++
 rtl/fft_bfly_addr_gen.sv | 144 ++++++++++++++
 tb/tb_fft_bfly_addr_gen.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants and FSM state encoding for the FFT butterfly address sequencer.
// Derived widths are recomputed per instance from LOG2N via stage_w().
package fft_pkg;

  localparam int LOG2N_DEF = 5;

  function automatic int stage_w(input int log2n);
    return (log2n > 1) ? $clog2(log2n) : 1;
  endfunction

  localparam int N       = 1 << LOG2N_DEF;
  localparam int HALF_N  = N / 2;
  localparam int STAGE_W = stage_w(LOG2N_DEF);
  localparam int TW_W    = LOG2N_DEF - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_FIN
  } state_t;

endpackage

// File: rtl/fft_bfly_addr_gen_if.sv
// Butterfly read-address stream: one (addr_a, addr_b, tw_idx) triple per valid/ready beat.
// master drives the triple and valid, slave returns ready.
interface fft_bfly_addr_gen_if #(
  parameter int LOG2N = fft_pkg::LOG2N_DEF
);
  import fft_pkg::*;

  localparam int SW = stage_w(LOG2N);

  logic             valid;
  logic             ready;
  logic [LOG2N-1:0] addr_a;
  logic [LOG2N-1:0] addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic [SW-1:0]    stage;
  logic             last;

  modport master (
    output valid, addr_a, addr_b, tw_idx, stage, last,
    input  ready
  );

  modport slave (
    input  valid, addr_a, addr_b, tw_idx, stage, last,
    output ready
  );

endinterface

// File: rtl/fft_bfly_addr_map.sv
// Combinational (stage, butterfly) -> (addr_a, addr_b, twiddle index) for in-place radix-2 DIT.
// Zero latency; no flow control.
module fft_bfly_addr_map #(
  parameter int LOG2N = fft_pkg::LOG2N_DEF
) (
  input  logic [fft_pkg::stage_w(LOG2N)-1:0] s,
  input  logic [LOG2N-2:0]                   k,
  output logic [LOG2N-1:0]                   addr_a,
  output logic [LOG2N-1:0]                   addr_b,
  output logic [LOG2N-2:0]                   tw_idx
);
  import fft_pkg::*;

  localparam int SW  = stage_w(LOG2N);
  localparam int K_W = LOG2N - 1;

  logic [K_W-1:0] h_k;
  logic [K_W-1:0] pos;
  logic [K_W-1:0] grp;

  // On the last stage h no longer fits in K_W bits; it wraps to 0 so the mask becomes all ones.
  assign h_k    = K_W'(1) << s;
  assign pos    = k & (h_k - K_W'(1));
  assign grp    = k >> s;
  assign addr_a = ((LOG2N'(grp) << s) << 1) | LOG2N'(pos);
  assign addr_b = addr_a + (LOG2N'(1) << s);
  assign tw_idx = pos << (SW'(K_W) - s);

endmodule

// File: rtl/fft_bfly_addr_gen.sv
// Read-side address sequencer for the in-place radix-2 DIT FFT; first triple 1 cycle after start.
// Triple holds while ready is low; GAP idle cycles between stages ignore ready.
module fft_bfly_addr_gen #(
  parameter int LOG2N = fft_pkg::LOG2N_DEF,
  parameter int GAP   = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  output logic                busy,
  output logic                done,
  fft_bfly_addr_gen_if.master bus
);
  import fft_pkg::*;

  localparam int SW  = stage_w(LOG2N);
  localparam int K_W = LOG2N - 1;
  localparam int G_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [SW-1:0]  S_LAST = SW'(LOG2N - 1);
  localparam logic [K_W-1:0] K_LAST = '1;
  localparam logic [G_W-1:0] G_LAST = G_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           state, state_nxt;
  logic [SW-1:0]    s, s_nxt;
  logic [K_W-1:0]   k, k_nxt;
  logic [G_W-1:0]   g, g_nxt;
  logic             valid_q, valid_nxt;
  logic             last_q, last_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic [LOG2N-1:0] a_q, b_q, a_map, b_map;
  logic [K_W-1:0]   tw_q, tw_map;
  logic             hs;

  assign hs = valid_q & bus.ready;

  // Map the next (s, k) so the registered triple lines up with the registered counters.
  fft_bfly_addr_map #(.LOG2N(LOG2N)) u_map (
    .s      (s_nxt),
    .k      (k_nxt),
    .addr_a (a_map),
    .addr_b (b_map),
    .tw_idx (tw_map)
  );

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    k_nxt     = k;
    g_nxt     = g;
    valid_nxt = valid_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        if (start) begin
          state_nxt = ST_RUN;
          s_nxt     = '0;
          k_nxt     = '0;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        if (hs) begin
          if (k != K_LAST) begin
            k_nxt = k + 1'b1;
          end else if (s == S_LAST) begin
            state_nxt = ST_FIN;
            valid_nxt = 1'b0;
            done_nxt  = 1'b1;
            s_nxt     = '0;
            k_nxt     = '0;
          end else if (GAP > 0) begin
            state_nxt = ST_GAP;
            g_nxt     = '0;
            valid_nxt = 1'b0;
          end else begin
            s_nxt = s + 1'b1;
            k_nxt = '0;
          end
        end
      end
      ST_GAP: begin
        if (g == G_LAST) begin
          state_nxt = ST_RUN;
          s_nxt     = s + 1'b1;
          k_nxt     = '0;
          g_nxt     = '0;
          valid_nxt = 1'b1;
        end else begin
          g_nxt = g + 1'b1;
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
      default: state_nxt = ST_IDLE;
    endcase
    last_nxt = valid_nxt && (s_nxt == S_LAST) && (k_nxt == K_LAST);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= ST_IDLE;
      s       <= '0;
      k       <= '0;
      g       <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
    end else begin
      state   <= state_nxt;
      s       <= s_nxt;
      k       <= k_nxt;
      g       <= g_nxt;
      valid_q <= valid_nxt;
      last_q  <= last_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      a_q     <= valid_nxt ? a_map  : '0;
      b_q     <= valid_nxt ? b_map  : '0;
      tw_q    <= valid_nxt ? tw_map : '0;
    end
  end

  assign bus.valid  = valid_q;
  assign bus.last   = last_q;
  assign bus.addr_a = a_q;
  assign bus.addr_b = b_q;
  assign bus.tw_idx = tw_q;
  assign bus.stage  = s;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fft_bfly_addr_gen.sv
// Bench for fft_bfly_addr_gen: three configurations plus an exhaustive sweep of the address map.
// Expected triples come from a loop-based FFT reference pushed into per-DUT scoreboard queues.
module tb_fft_bfly_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic clr3 = 1'b1, clr0 = 1'b1, clr5 = 1'b1;
  logic start3 = 1'b0, start0 = 1'b0, start5 = 1'b0;
  logic busy3, busy0, busy5, done3, done0, done5;

  fft_bfly_addr_gen_if #(.LOG2N(3)) if3 ();
  fft_bfly_addr_gen_if #(.LOG2N(3)) if0 ();
  fft_bfly_addr_gen_if #(.LOG2N(5)) if5 ();

  fft_bfly_addr_gen #(.LOG2N(3), .GAP(2)) u3 (
    .clk(clk), .clr(clr3), .start(start3), .busy(busy3), .done(done3), .bus(if3));
  fft_bfly_addr_gen #(.LOG2N(3), .GAP(0)) u0 (
    .clk(clk), .clr(clr0), .start(start0), .busy(busy0), .done(done0), .bus(if0));
  fft_bfly_addr_gen #(.LOG2N(5), .GAP(4)) u5 (
    .clk(clk), .clr(clr5), .start(start5), .busy(busy5), .done(done5), .bus(if5));

  logic [2:0] ms;
  logic [3:0] mk, mt;
  logic [4:0] ma, mb;
  fft_bfly_addr_map #(.LOG2N(5)) um (
    .s(ms), .k(mk), .addr_a(ma), .addr_b(mb), .tw_idx(mt));

  logic [63:0] q3[$], q0[$], q5[$];
  int ndone3 = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] tw, input logic [7:0] st, input logic l);
    return {31'b0, l, st, tw, b, a};
  endfunction

  // Reference: textbook DIT loop nest (group outer, offset inner), twiddle stride N/(2h).
  function automatic logic [63:0] model(input int log2n, input int s, input int k);
    int h, grp, j, a, b, tw;
    logic l;
    h   = 1 << s;
    grp = k / h;
    j   = k % h;
    a   = grp * 2 * h + j;
    b   = a + h;
    tw  = j * ((1 << log2n) / (2 * h));
    l   = (s == log2n - 1) && (k == (1 << (log2n - 1)) - 1);
    return pk(8'(a), 8'(b), 8'(tw), 8'(s), l);
  endfunction

  function automatic int qsize(input int w);
    case (w)
      0:       return q3.size();
      1:       return q0.size();
      default: return q5.size();
    endcase
  endfunction

  function automatic logic [63:0] qfront(input int w);
    case (w)
      0:       return q3[0];
      1:       return q0[0];
      default: return q5[0];
    endcase
  endfunction

  function automatic void qpop(input int w);
    case (w)
      0:       void'(q3.pop_front());
      1:       void'(q0.pop_front());
      default: void'(q5.pop_front());
    endcase
  endfunction

  function automatic void push_xfer(input int w, input int log2n);
    for (int s = 0; s < log2n; s++)
      for (int k = 0; k < (1 << (log2n - 1)); k++)
        case (w)
          0:       q3.push_back(model(log2n, s, k));
          1:       q0.push_back(model(log2n, s, k));
          default: q5.push_back(model(log2n, s, k));
        endcase
  endfunction

  // Every valid cycle is compared against the queue head; a beat only retires on handshake.
  task automatic mon(input int w, input string tag, input logic v, input logic r,
                     input logic [63:0] got);
    if (v) begin
      if (qsize(w) == 0) check({tag, "_extra_valid"}, 64'(v), 64'd0);
      else begin
        check($sformatf("%s_sb%0d", tag, qsize(w)), got, qfront(w));
        if (r) qpop(w);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, "u3", if3.valid, if3.ready,
        pk(8'(if3.addr_a), 8'(if3.addr_b), 8'(if3.tw_idx), 8'(if3.stage), if3.last));
    mon(1, "u0", if0.valid, if0.ready,
        pk(8'(if0.addr_a), 8'(if0.addr_b), 8'(if0.tw_idx), 8'(if0.stage), if0.last));
    mon(2, "u5", if5.valid, if5.ready,
        pk(8'(if5.addr_a), 8'(if5.addr_b), 8'(if5.tw_idx), 8'(if5.stage), if5.last));
    if (done3) ndone3++;
  end

  // Cycle-table driver for the LOG2N=3, GAP=2 instance; cycle 0 is the first driven cycle.
  task automatic run3(input string tag, input int ncyc, input logic [63:0] st_mask,
                      input logic [63:0] acc_mask, input logic [63:0] rlo_mask,
                      input logic [63:0] vmask, input int exp_done, input int exp_ndone);
    int nd = 0;
    int dc = -1;
    for (int c = 0; c < ncyc; c++) begin
      start3    = st_mask[c];
      if3.ready = !rlo_mask[c];
      if (acc_mask[c]) push_xfer(0, 3);
      @(negedge clk);
      check($sformatf("%s_valid_c%0d", tag, c), 64'(if3.valid), 64'(vmask[c]));
      if (c == exp_done)     check($sformatf("%s_busy_at_done", tag), 64'(busy3), 64'd1);
      if (c == exp_done + 1) check($sformatf("%s_busy_after", tag), 64'(busy3), 64'd0);
      if (done3) begin
        nd++;
        if (dc < 0) dc = c;
      end
      @(posedge clk); #1;
    end
    start3    = 1'b0;
    if3.ready = 1'b1;
    check({tag, "_done_cycle"}, 64'(dc), 64'(exp_done));
    check({tag, "_done_count"}, 64'(nd), 64'(exp_ndone));
    check({tag, "_queue_empty"}, 64'(qsize(0)), 64'd0);
  endtask

  localparam logic [63:0] V_T1 = 64'h1E79E;

  initial begin
    logic [31:0] seen[5];
    int hs, gapc, dup, nd_before;
    logic to;
    if3.ready = 1'b1;
    if0.ready = 1'b1;
    if5.ready = 1'b1;

    #12;
    check("rst_valid",  64'(if3.valid),  64'd0);
    check("rst_last",   64'(if3.last),   64'd0);
    check("rst_busy",   64'(busy3),      64'd0);
    check("rst_done",   64'(done3),      64'd0);
    check("rst_addr_a", 64'(if3.addr_a), 64'd0);
    check("rst_addr_b", 64'(if3.addr_b), 64'd0);
    check("rst_tw",     64'(if3.tw_idx), 64'd0);
    check("rst_stage",  64'(if3.stage),  64'd0);

    for (int s = 0; s < 5; s++)
      for (int k = 0; k < 16; k++) begin
        ms = 3'(s);
        mk = 4'(k);
        #1;
        check($sformatf("map_s%0d_k%0d", s, k),
              pk(8'(ma), 8'(mb), 8'(mt), 8'(s), (s == 4) && (k == 15)), model(5, s, k));
      end

    @(posedge clk); #1;
    clr3 = 1'b0; clr0 = 1'b0; clr5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run3("t1", 19, 64'h1, 64'h1, 64'h0, V_T1, 17, 1);
    repeat (3) @(posedge clk);
    #1;
    run3("t2", 21, 64'h1, 64'h1, 64'hC, 64'h79E7E, 19, 1);
    repeat (3) @(posedge clk);
    #1;
    run3("t4", 37, 64'h60021, 64'h40001, 64'h0, V_T1 | (V_T1 << 18), 17, 2);
    repeat (3) @(posedge clk);
    #1;

    // Abort in the middle of stage 1 with an asynchronous clr.
    nd_before = ndone3;
    start3 = 1'b1;
    push_xfer(0, 3);
    @(posedge clk); #1;
    start3 = 1'b0;
    repeat (7) @(posedge clk);
    #4;
    check("clr_pre_valid", 64'(if3.valid), 64'd1);
    clr3 = 1'b1;
    #1;
    check("clr_valid",  64'(if3.valid),  64'd0);
    check("clr_last",   64'(if3.last),   64'd0);
    check("clr_busy",   64'(busy3),      64'd0);
    check("clr_done",   64'(done3),      64'd0);
    check("clr_addr_a", 64'(if3.addr_a), 64'd0);
    check("clr_addr_b", 64'(if3.addr_b), 64'd0);
    check("clr_tw",     64'(if3.tw_idx), 64'd0);
    check("clr_stage",  64'(if3.stage),  64'd0);
    q3.delete();
    repeat (3) @(posedge clk);
    #1;
    clr3 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("clr_no_done", 64'(ndone3), 64'(nd_before));
    run3("t5", 19, 64'h1, 64'h1, 64'h0, V_T1, 17, 1);

    // GAP=0: stages run back to back.
    start0 = 1'b1;
    push_xfer(1, 3);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check($sformatf("g0_valid_c%0d", c), 64'(if0.valid), 64'((c >= 1) && (c <= 12)));
      check($sformatf("g0_done_c%0d", c),  64'(done0),     64'(c == 13));
      @(posedge clk); #1;
      start0 = 1'b0;
    end
    check("g0_queue_empty", 64'(qsize(1)), 64'd0);

    // LOG2N=5 with random backpressure.
    for (int i = 0; i < 5; i++) seen[i] = '0;
    hs = 0; gapc = 0; dup = 0; to = 1'b1;
    start5 = 1'b1;
    push_xfer(2, 5);
    for (int c = 0; c < 2000; c++) begin
      if5.ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (if5.valid && if5.ready) begin
        hs++;
        if (seen[if5.stage][if5.addr_a] || seen[if5.stage][if5.addr_b]) dup++;
        seen[if5.stage][if5.addr_a] = 1'b1;
        seen[if5.stage][if5.addr_b] = 1'b1;
      end
      if (busy5 && !if5.valid && !done5) gapc++;
      if (done5) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
      start5 = 1'b0;
    end
    start5 = 1'b0;
    if5.ready = 1'b1;
    check("l5_timeout",    64'(to),   64'd0);
    check("l5_handshakes", 64'(hs),   64'd80);
    check("l5_gap_cycles", 64'(gapc), 64'd16);
    check("l5_dup_addr",   64'(dup),  64'd0);
    for (int i = 0; i < 5; i++)
      check($sformatf("l5_cover_s%0d", i), 64'(seen[i]), 64'hFFFF_FFFF);
    check("l5_queue_empty", 64'(qsize(2)), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
